// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Width needed to hold a 1-based index up to and including n.
    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/matmul_if.sv
// Fixed-point common ports (clock, reset, number format) and the multiply handshake bundle.
interface fixedp #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8
) (
    input logic clk,
    input logic reset
);
    modport slave (input clk, input reset);
endinterface

interface matmul_if #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned A_ROWS        = 1,
    parameter int unsigned A_COLS_B_ROWS = 1,
    parameter int unsigned B_COLS        = 1
);
    logic                                        start;
    logic [A_ROWS:1][A_COLS_B_ROWS:1][WIDTH-1:0] a;
    logic [A_COLS_B_ROWS:1][B_COLS:1][WIDTH-1:0] b;
    logic                                        busy;
    logic                                        done;
    logic [A_ROWS:1][B_COLS:1][WIDTH-1:0]        f;

    modport master (output start, output a, output b, input busy, input done, input f);
    modport slave  (input start, input a, input b, output busy, output done, output f);
endinterface

// File: rtl/matmul_idx_gen.sv
// Nested row/col/k counter (k innermost) with registered first/last/final tags.
module matmul_idx_gen import matmul_pkg::*; #(
    parameter int unsigned A_ROWS        = 1,
    parameter int unsigned A_COLS_B_ROWS = 1,
    parameter int unsigned B_COLS        = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 step,
    input  logic                                 clear,
    output logic [idx_w(A_ROWS)-1:0]             row,
    output logic [idx_w(B_COLS)-1:0]             col,
    output logic [idx_w(A_COLS_B_ROWS)-1:0]      k,
    output logic                                 first,
    output logic                                 last,
    output logic                                 is_final
);
    localparam int unsigned RW = idx_w(A_ROWS);
    localparam int unsigned CW = idx_w(B_COLS);
    localparam int unsigned KW = idx_w(A_COLS_B_ROWS);

    localparam logic [RW-1:0] R_ONE = RW'(1);
    localparam logic [RW-1:0] R_MAX = RW'(A_ROWS);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_MAX = CW'(B_COLS);
    localparam logic [KW-1:0] K_ONE = KW'(1);
    localparam logic [KW-1:0] K_MAX = KW'(A_COLS_B_ROWS);

    localparam logic INIT_LAST  = (A_COLS_B_ROWS == 1);
    localparam logic INIT_FINAL = (A_ROWS == 1) && (B_COLS == 1) && (A_COLS_B_ROWS == 1);

    logic [RW-1:0] row_n;
    logic [CW-1:0] col_n;
    logic [KW-1:0] k_n;

    always_comb begin
        row_n = row;
        col_n = col;
        k_n   = k;
        if (k == K_MAX) begin
            k_n = K_ONE;
            if (col == C_MAX) begin
                col_n = C_ONE;
                row_n = (row == R_MAX) ? R_ONE : row + R_ONE;
            end else begin
                col_n = col + C_ONE;
            end
        end else begin
            k_n = k + K_ONE;
        end
    end

    // Tags are precomputed from the next indices so they line up with row/col/k.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row      <= R_ONE;
            col      <= C_ONE;
            k        <= K_ONE;
            first    <= 1'b1;
            last     <= INIT_LAST;
            is_final <= INIT_FINAL;
        end else if (clear) begin
            row      <= R_ONE;
            col      <= C_ONE;
            k        <= K_ONE;
            first    <= 1'b1;
            last     <= INIT_LAST;
            is_final <= INIT_FINAL;
        end else if (step) begin
            row      <= row_n;
            col      <= col_n;
            k        <= k_n;
            first    <= (k_n == K_ONE);
            last     <= (k_n == K_MAX);
            is_final <= (row_n == R_MAX) && (col_n == C_MAX) && (k_n == K_MAX);
        end
    end

endmodule

// File: rtl/smul.sv
// Signed fixed-point multiply: full product, arithmetic shift by FRAC, truncate to WIDTH.
module smul #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] p_c
);
    logic signed [2*WIDTH-1:0] full;

    assign full = $signed(x) * $signed(y);
    assign p_c  = WIDTH'(full >>> FRAC);

endmodule

// File: rtl/matmul_seq.sv
// Sequential matrix multiplier: one shared smul and one accumulator, one product per clock.
module matmul_seq import matmul_pkg::*; #(
    parameter int unsigned A_ROWS        = 1,
    parameter int unsigned A_COLS_B_ROWS = 1,
    parameter int unsigned B_COLS        = 1
) (
    fixedp.slave    g,
    matmul_if.slave m
);
    localparam int unsigned W    = g.WIDTH;
    localparam int unsigned FRAC = g.FRAC;
    localparam int unsigned RW   = idx_w(A_ROWS);
    localparam int unsigned CW   = idx_w(B_COLS);
    localparam int unsigned KW   = idx_w(A_COLS_B_ROWS);

    state_t state;
    logic   busy;
    logic   done;

    logic [A_ROWS:1][A_COLS_B_ROWS:1][W-1:0] ra;
    logic [A_COLS_B_ROWS:1][B_COLS:1][W-1:0] rb;
    logic [A_ROWS:1][B_COLS:1][W-1:0]        f;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [KW-1:0] k;
    logic          first;
    logic          last;
    logic          is_final;
    logic          step;
    logic          clear;

    logic [W-1:0]  sa_c;
    logic [W-1:0]  sb_c;
    logic [W-1:0]  prod_c;
    logic [W-1:0]  sum_c;

    logic [W-1:0]  p;
    logic          p_vld;
    logic [RW-1:0] p_row;
    logic [CW-1:0] p_col;
    logic          p_first;
    logic          p_last;
    logic [W-1:0]  acc;

    assign clear = (state == IDLE) && m.start;
    assign step  = (state == RUN);

    matmul_idx_gen #(
        .A_ROWS        (A_ROWS),
        .A_COLS_B_ROWS (A_COLS_B_ROWS),
        .B_COLS        (B_COLS)
    ) u_idx (
        .clk      (g.clk),
        .reset    (g.reset),
        .step     (step),
        .clear    (clear),
        .row      (row),
        .col      (col),
        .k        (k),
        .first    (first),
        .last     (last),
        .is_final (is_final)
    );

    assign sa_c = ra[row][k];
    assign sb_c = rb[k][col];

    smul #(.WIDTH(W), .FRAC(FRAC)) u_smul (
        .x   (sa_c),
        .y   (sb_c),
        .p_c (prod_c)
    );

    // Control: operand capture, product issue and handshake.
    always_ff @(posedge g.clk or posedge g.reset) begin
        if (g.reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            ra      <= '0;
            rb      <= '0;
            p       <= '0;
            p_vld   <= 1'b0;
            p_row   <= RW'(1);
            p_col   <= CW'(1);
            p_first <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            done  <= 1'b0;
            p_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (m.start) begin
                        ra    <= m.a;
                        rb    <= m.b;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    p       <= prod_c;
                    p_vld   <= 1'b1;
                    p_row   <= row;
                    p_col   <= col;
                    p_first <= first;
                    p_last  <= last;
                    if (is_final) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Wrapping accumulate; a tagged-last product completes one f element.
    assign sum_c = (p_first ? W'(0) : acc) + p;

    always_ff @(posedge g.clk or posedge g.reset) begin
        if (g.reset) begin
            acc <= '0;
            f   <= '0;
        end else if (p_vld) begin
            acc <= sum_c;
            if (p_last) begin
                f[p_row][p_col] <= sum_c;
            end
        end
    end

    assign m.busy = busy;
    assign m.done = done;
    assign m.f    = f;

endmodule

// File: tb/tb_matmul_seq.sv
// Scoreboard bench for matmul_seq across 2x2x2, 1x1x1, 1x3x1 and 1x2x1 shapes (Q8.8, 16 bit).
module tb_matmul_seq;
    localparam int unsigned W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fixedp #(.WIDTH(W), .FRAC(8)) g (.clk(clk), .reset(reset));

    matmul_if #(.WIDTH(W), .A_ROWS(2), .A_COLS_B_ROWS(2), .B_COLS(2)) m22 ();
    matmul_if #(.WIDTH(W), .A_ROWS(1), .A_COLS_B_ROWS(1), .B_COLS(1)) m111 ();
    matmul_if #(.WIDTH(W), .A_ROWS(1), .A_COLS_B_ROWS(3), .B_COLS(1)) m131 ();
    matmul_if #(.WIDTH(W), .A_ROWS(1), .A_COLS_B_ROWS(2), .B_COLS(1)) m121 ();

    matmul_seq #(.A_ROWS(2), .A_COLS_B_ROWS(2), .B_COLS(2)) u22  (.g(g), .m(m22));
    matmul_seq #(.A_ROWS(1), .A_COLS_B_ROWS(1), .B_COLS(1)) u111 (.g(g), .m(m111));
    matmul_seq #(.A_ROWS(1), .A_COLS_B_ROWS(3), .B_COLS(1)) u131 (.g(g), .m(m131));
    matmul_seq #(.A_ROWS(1), .A_COLS_B_ROWS(2), .B_COLS(1)) u121 (.g(g), .m(m121));

    typedef struct {
        int          id;
        logic [63:0] f;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    int   nprod     [4] = '{8, 1, 3, 2};
    int   done_cnt  [4] = '{0, 0, 0, 0};
    int   st        [4] = '{0, 0, 0, 0};
    int   bcnt      [4] = '{0, 0, 0, 0};
    logic prev_busy [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic prev_done [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

    localparam logic [63:0] A22  = 64'h0400_0300_0200_0100;
    localparam logic [63:0] B22  = 64'h0800_0700_0600_0500;
    localparam logic [63:0] A2   = 64'h0200_0080_ff00_0100;
    localparam logic [63:0] AJNK = 64'h1000_1000_1000_1000;
    localparam logic [63:0] A131 = 64'h0000_0300_0200_0100;
    localparam logic [63:0] B131 = 64'h0000_0200_0040_0080;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] el(input logic [63:0] v, input int ncol, input int r, input int c);
        return v[((r - 1) * ncol + (c - 1)) * 16 +: 16];
    endfunction

    // Q8.8 signed multiply, truncated toward minus infinity.
    function automatic logic [15:0] fxmul(input logic [15:0] x, input logic [15:0] y);
        int xi;
        int yi;
        int pr;
        xi = int'($signed(x));
        yi = int'($signed(y));
        pr = xi * yi;
        return 16'(pr >>> 8);
    endfunction

    function automatic logic [63:0] model(input int nr, input int nk, input int nc,
                                          input logic [63:0] av, input logic [63:0] bv);
        logic [63:0] fv;
        logic [15:0] s;
        fv = '0;
        for (int r = 1; r <= nr; r++) begin
            for (int c = 1; c <= nc; c++) begin
                s = '0;
                for (int kk = 1; kk <= nk; kk++) begin
                    s = s + fxmul(el(av, nk, r, kk), el(bv, nc, kk, c));
                end
                fv[((r - 1) * nc + (c - 1)) * 16 +: 16] = s;
            end
        end
        return fv;
    endfunction

    task automatic set_start(input int id, input logic s);
        case (id)
            0: m22.start  = s;
            1: m111.start = s;
            2: m131.start = s;
            default: m121.start = s;
        endcase
    endtask

    task automatic drive(input int id, input logic s, input logic [63:0] av, input logic [63:0] bv);
        set_start(id, s);
        case (id)
            0: begin m22.a  = av;        m22.b  = bv;        end
            1: begin m111.a = av[15:0];  m111.b = bv[15:0];  end
            2: begin m131.a = av[47:0];  m131.b = bv[47:0];  end
            default: begin m121.a = av[31:0]; m121.b = bv[31:0]; end
        endcase
    endtask

    task automatic mon(input int id, input logic busy, input logic done, input logic [63:0] f);
        exp_t e;
        if (busy && !prev_busy[id]) begin
            st[id]   = cyc;
            bcnt[id] = 0;
        end
        if (busy) bcnt[id]++;
        if (done) begin
            done_cnt[id]++;
            check($sformatf("busy_at_done%0d", id), 64'(busy), 64'(0));
            check($sformatf("done_pulse%0d", id), 64'(prev_done[id]), 64'(0));
            check($sformatf("latency%0d", id), 64'(cyc - st[id]), 64'(nprod[id] + 1));
            check($sformatf("busy_len%0d", id), 64'(bcnt[id]), 64'(nprod[id] + 1));
            check($sformatf("sb_owner%0d", id), 64'((sbq.size() == 0) ? -1 : sbq[0].id), 64'(id));
            if (sbq.size() != 0 && sbq[0].id == id) begin
                e = sbq.pop_front();
                check($sformatf("f%0d", id), f, e.f);
            end
        end
        prev_busy[id] = busy;
        prev_done[id] = done;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                prev_busy[i] = 1'b0;
                prev_done[i] = 1'b0;
                bcnt[i]      = 0;
            end
        end else begin
            mon(0, m22.busy,  m22.done,  64'(m22.f));
            mon(1, m111.busy, m111.done, 64'(m111.f));
            mon(2, m131.busy, m131.done, 64'(m131.f));
            mon(3, m121.busy, m121.done, 64'(m121.f));
        end
    end

    task automatic wait_done(input int id, input int budget);
        int n0;
        int i;
        n0 = done_cnt[id];
        i  = 0;
        while (done_cnt[id] == n0 && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        check($sformatf("done_seen%0d", id), 64'(done_cnt[id] - n0), 64'(1));
    endtask

    task automatic run(input int id, input logic [63:0] av, input logic [63:0] bv,
                       input int nr, input int nk, input int nc);
        exp_t e;
        e.id = id;
        e.f  = model(nr, nk, nc, av, bv);
        sbq.push_back(e);
        @(posedge clk); #1;
        drive(id, 1'b1, av, bv);
        @(posedge clk); #1;
        set_start(id, 1'b0);
        wait_done(id, 40);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n0;
        int   t_prev;
        exp_t e;
        t_prev = 0;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, '0, '0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(m22.busy), 64'(0));
        check("rst_done", 64'(m22.done), 64'(0));
        check("rst_f",    64'(m22.f),    64'(0));
        @(negedge clk);
        reset = 1'b0;

        // Basic 2x2x2 and 1x1x1 (K=1, no carry-over between runs)
        run(0, A22, B22, 2, 2, 2);
        check("f22_ref", 64'(m22.f), 64'h3200_2b00_1600_1300);
        run(1, 64'h0180, 64'h0200, 1, 1, 1);
        check("f111_ref", 64'(m111.f), 64'h0300);
        run(1, 64'hff00, 64'h0080, 1, 1, 1);
        check("f111_neg", 64'(m111.f), 64'hff80);

        // Start and operand changes while busy are ignored
        e.id = 0;
        e.f  = model(2, 2, 2, A2, B22);
        sbq.push_back(e);
        n0 = done_cnt[0];
        @(posedge clk); #1;
        drive(0, 1'b1, A2, B22);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 1'b1, AJNK, B22);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        wait_done(0, 40);
        repeat (15) @(posedge clk);
        check("no_second_done", 64'(done_cnt[0] - n0), 64'(1));

        // Asynchronous reset mid-run, then a clean rerun
        n0 = done_cnt[0];
        @(posedge clk); #1;
        drive(0, 1'b1, A22, B22);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(m22.busy), 64'(0));
        check("midrst_done", 64'(m22.done), 64'(0));
        check("midrst_f",    64'(m22.f),    64'(0));
        @(posedge clk); #2;
        reset = 1'b0;
        run(0, A2, B22, 2, 2, 2);
        check("abort_no_done", 64'(done_cnt[0] - n0), 64'(1));

        // Start held high: one result every N+2 cycles
        for (int i = 0; i < 3; i++) begin
            e.id = 2;
            e.f  = model(1, 3, 1, A131, B131);
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        drive(2, 1'b1, A131, B131);
        for (int i = 0; i < 3; i++) begin
            wait_done(2, 20);
            if (i > 0) check("period", 64'(cyc - t_prev), 64'(5));
            t_prev = cyc;
        end
        set_start(2, 1'b0);
        check("f131_ref", 64'(m131.f), 64'h0700);

        // Accumulator wraps modulo 2^16
        run(3, 64'h7fff_7fff, 64'h0100_0100, 1, 2, 1);
        check("f121_wrap", 64'(m121.f), 64'hfffe);

        repeat (10) @(posedge clk);
        check("sb_empty", 64'(sbq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
